// File: rtl/prog_loader_pkg.sv
// Shared definitions for the serial program loader.
// Holds the FSM state encoding and the default sizing parameters.
package prog_loader_pkg;

  localparam int MAX_WORDS_DEF = 32;
  localparam int ADDR_W_DEF    = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_LOAD,
    ST_CHECK,
    ST_FIN
  } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Loader bus: host byte stream in, imem byte-write port and status out.
// slave = loader side, master = host / memory / test side.
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_we;
  logic              busy;
  logic              done;
  logic              error;
  logic              cpu_hold;

  modport slave (
    input  start,
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output mem_addr,
    output mem_data,
    output mem_we,
    output busy,
    output done,
    output error,
    output cpu_hold
  );

  modport master (
    output start,
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  mem_addr,
    input  mem_data,
    input  mem_we,
    input  busy,
    input  done,
    input  error,
    input  cpu_hold
  );

endinterface

// File: rtl/prog_loader.sv
// Serial program loader: length byte, N image bytes, XOR checksum byte.
// Ports: clk, rst (sync, active high), bus (prog_loader_if.slave).
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int MAX_WORDS = MAX_WORDS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  prog_loader_if.slave    bus
);

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        idx_q, idx_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;

  logic rdy;
  logic acc;
  logic len_bad;

  assign rdy = (state_q == ST_LEN)  ||
               (state_q == ST_LOAD) ||
               (state_q == ST_CHECK);

  assign acc = rdy && bus.byte_valid;

  assign len_bad = (bus.byte_in == 8'd0) ||
                   (int'(bus.byte_in) > MAX_WORDS);

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = done_q;
    error_d = error_q;
    csum_d  = csum_q;
    len_d   = len_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          csum_d  = 8'd0;
          busy_d  = 1'b1;
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (acc) begin
          if (len_bad) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            len_d   = bus.byte_in;
            idx_d   = 8'd0;
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (acc) begin
          csum_d = csum_q ^ bus.byte_in;
          we_d   = 1'b1;
          addr_d = ADDR_W'(idx_q);
          data_d = bus.byte_in;
          idx_d  = idx_q + 8'd1;
          // idx_q is the index of the byte just taken
          if (idx_q == len_q - 8'd1) begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (acc) begin
          if (bus.byte_in == csum_q) begin
            done_d  = 1'b1;
            state_d = ST_FIN;
          end else begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_FIN: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      csum_q  <= 8'd0;
      len_q   <= 8'd0;
      idx_q   <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      csum_q  <= csum_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // rst masks the strobe so a write queued the cycle before never lands
  assign bus.mem_we     = we_q & ~rst;
  assign bus.byte_ready = rdy & ~rst;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_data   = data_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.cpu_hold   = busy_q | ~done_q;

endmodule
